// File: rtl/spi_bridge_pkg.sv
// rtl/spi_bridge_pkg.sv - shared types and default widths for the SPI register-bus bridge
package spi_bridge_pkg;

    localparam int ADDRESS_WIDTH = 15;
    localparam int DATA_WIDTH    = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } bridge_state_t;

    // Packed command layout; the bridge packs FIFO entries in this same field order.
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    wdata;
        logic                     rd_wr;
    } bridge_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous show-ahead command FIFO
module cmd_fifo #(
    parameter int width = 32,
    parameter int depth = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int ptr_width = $clog2(depth);

    logic [width-1:0]   mem [depth];
    logic [ptr_width:0] wr_ptr;
    logic [ptr_width:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Extra pointer bit tells full from empty when the indices coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ptr_width] != rd_ptr[ptr_width]) &&
                     (wr_ptr[ptr_width-1:0] == rd_ptr[ptr_width-1:0]);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[ptr_width-1:0]];

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[ptr_width-1:0]] <= wdata;
    end

endmodule

// File: rtl/spi_bus_bridge.sv
// rtl/spi_bus_bridge.sv - issues buffered SPI register commands on the req/ack register bus
module spi_bus_bridge
    import spi_bridge_pkg::*;
#(
    parameter int                    address_width  = ADDRESS_WIDTH,
    parameter int                    data_width     = DATA_WIDTH,
    parameter int                    fifo_depth     = 2,
    parameter int                    timeout_cycles = 16,
    parameter logic [data_width-1:0] timeout_data   = data_width'('hDEAD)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cmd_valid_i,
    input  logic [address_width-1:0] cmd_addr_i,
    input  logic [data_width-1:0]    cmd_wdata_i,
    input  logic                     cmd_rd_wr_i,
    output logic [data_width-1:0]    rsp_data_o,
    output logic                     rsp_valid_o,
    output logic                     bus_req_o,
    output logic                     bus_we_o,
    output logic [address_width-1:0] bus_addr_o,
    output logic [data_width-1:0]    bus_wdata_o,
    input  logic                     bus_ack_i,
    input  logic [data_width-1:0]    bus_rdata_i,
    output logic                     busy_o,
    output logic                     err_timeout_o,
    output logic                     err_overflow_o,
    input  logic                     err_clear_i
);

    localparam int cmd_width = address_width + data_width + 1;
    localparam int cnt_width = $clog2(timeout_cycles);
    localparam logic [cnt_width-1:0] cnt_last = cnt_width'(timeout_cycles - 1);

    bridge_state_t        state;
    bridge_state_t        state_next;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [cmd_width-1:0] fifo_wdata;
    logic [cmd_width-1:0] fifo_rdata;
    logic [cnt_width-1:0] cnt;
    logic                 ack_seen;
    logic                 expired;

    assign fifo_pop   = (state == IDLE) && !fifo_empty;
    assign fifo_push  = cmd_valid_i && (!fifo_full || fifo_pop);
    assign fifo_wdata = {cmd_addr_i, cmd_wdata_i, cmd_rd_wr_i};
    assign ack_seen   = (state == ACCESS) && bus_req_o && bus_ack_i;
    // Ack on the final cycle still counts as a normal completion.
    assign expired    = (state == ACCESS) && !bus_ack_i && (cnt == cnt_last);

    cmd_fifo #(
        .width (cmd_width),
        .depth (fifo_depth)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (fifo_wdata),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = ACCESS;
            ACCESS:  if (ack_seen || expired) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rsp_data_o     <= '0;
            rsp_valid_o    <= 1'b0;
            bus_req_o      <= 1'b0;
            bus_we_o       <= 1'b0;
            bus_addr_o     <= '0;
            bus_wdata_o    <= '0;
            busy_o         <= 1'b0;
            err_timeout_o  <= 1'b0;
            err_overflow_o <= 1'b0;
            cnt            <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            busy_o      <= fifo_push || !fifo_empty || (state_next == ACCESS);

            if (fifo_pop) begin
                bus_req_o  <= 1'b1;
                bus_we_o   <= fifo_rdata[0];
                bus_addr_o <= fifo_rdata[cmd_width-1 -: address_width];
                if (fifo_rdata[0]) bus_wdata_o <= fifo_rdata[data_width:1];
                cnt <= '0;
            end else if (ack_seen) begin
                bus_req_o   <= 1'b0;
                rsp_valid_o <= 1'b1;
                if (!bus_we_o) rsp_data_o <= bus_rdata_i;
            end else if (expired) begin
                bus_req_o   <= 1'b0;
                rsp_valid_o <= 1'b1;
                if (!bus_we_o) rsp_data_o <= timeout_data;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end

            if (expired)          err_timeout_o <= 1'b1;
            else if (err_clear_i) err_timeout_o <= 1'b0;

            if (cmd_valid_i && fifo_full && !fifo_pop) err_overflow_o <= 1'b1;
            else if (err_clear_i)                       err_overflow_o <= 1'b0;
        end
    end

endmodule
